mem_refill_arbiter: RTL

- Arbitrates the single backing-memory port between the instruction-side refill requester and the data cache.
- The instruction-side requester issues line reads only. The data cache issues line refills (reads) and dirty-line writebacks (writes).
- Each granted transaction is a fixed-length burst of LINE_WORDS word beats, sequenced by an internal FSM and beat counter.
- Data side has priority, since its instruction is older and is stalling the pipeline. A streak counter prevents instruction-side starvation.

---
 rtl/mem_refill_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_refill_arbiter.sv
// Backing-memory port arbiter between the instruction refill requester and
// the data cache. Each grant runs a fixed LINE_WORDS-beat burst; the data
// side wins ties until its streak limit, after which the instruction side
// is served.
module mem_refill_arbiter #(
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [31:0]                   i_addr,
  output logic                          i_rvalid,
  output logic [31:0]                   i_rdata,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [31:0]                   d_addr,
  input  logic [31:0]                   d_wdata,
  output logic [$clog2(LINE_WORDS)-1:0] d_beat,
  output logic                          d_rvalid,
  output logic [31:0]                   d_rdata,
  output logic                          d_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_ack,
  output logic                          busy,
  output logic                          owner
);

  localparam int unsigned BW = $clog2(LINE_WORDS);
  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [BW-1:0] beat;
  logic [SW-1:0] streak;
  logic          grant_d;
  logic          last_beat;

  // Word-offset bits of the request addresses are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[BW+1:0], d_addr[BW+1:0]};

  // Data side wins unless it has already taken MAX_D_STREAK grants over a waiting i_req.
  assign grant_d   = d_req && (!i_req || (streak < SW'(MAX_D_STREAK)));
  assign last_beat = (beat == BW'(LINE_WORDS - 1));

  // Write data passes straight through from the data cache during write beats.
  assign mem_wdata = (mem_req && mem_we) ? d_wdata : 32'h0;

  // Arbitration, burst sequencing and registered output generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      streak   <= '0;
      owner    <= 1'b0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 32'h0;
      d_beat   <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= 32'h0;
      d_rdata  <= 32'h0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            state   <= BUSY;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            beat    <= '0;
            d_beat  <= '0;
            if (grant_d) begin
              owner    <= 1'b1;
              mem_we   <= d_we;
              mem_addr <= {d_addr[31:BW+2], BW'(0), 2'b00};
              if (i_req && (streak < SW'(MAX_D_STREAK)))
                streak <= streak + SW'(1);
            end else begin
              owner    <= 1'b0;
              mem_we   <= 1'b0;
              mem_addr <= {i_addr[31:BW+2], BW'(0), 2'b00};
              streak   <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!mem_we) begin
              i_rvalid <= !owner;
              d_rvalid <= owner;
              if (owner) d_rdata <= mem_rdata;
              else       i_rdata <= mem_rdata;
            end
            if (last_beat) begin
              state   <= DONE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              beat    <= '0;
              d_beat  <= '0;
              i_done  <= !owner;
              d_done  <= owner;
            end else begin
              beat     <= beat + BW'(1);
              d_beat   <= owner ? (beat + BW'(1)) : BW'(0);
              mem_addr <= {mem_addr[31:BW+2], beat + BW'(1), 2'b00};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
